signed_divider: RTL and testbench
=================================

# signed_divider

Sequential radix-2 signed divider: the inverse of the team's 8x8 sequential signed multiplier. It takes a 16-bit signed dividend and an 8-bit signed divisor and returns a 16-bit signed quotient and an 8-bit signed remainder after a fixed latency. It uses the same start/ready handshake as the multiplier, so verification can round-trip products back through it.

## Interface
- `DW`, 16: dividend and quotient width.
- `VW`, 8: divisor and remainder width.
- `clk` in, 1: single clock, rising edge.
- `rst_n` in, 1: asynchronous active-low reset.
- `start` in, 1: request pulse, sampled on `clk` rising edge only while `ready`=1.
- `Dividend` in, `DW`: signed dividend, sampled with `start`.
- `Divisor` in, `VW`: signed divisor, sampled with `start`.
- `Quotient` out, `DW`: signed quotient, truncated toward zero.
- `Remainder` out, `VW`: signed remainder.
- `ready` out, 1: high = idle and outputs valid.
- `err` out, 1: high = last result was divide-by-zero or overflow.

## Operation
- Reset values while `rst_n`=0 (async): `Quotient`=0, `Remainder`=0, `err`=0, `ready`=1, state IDLE, counter 0.
- States and transitions:
  - IDLE to LOAD on `start`=1.
  - LOAD: latch magnitudes and signs, then go to CALC.
  - CALC: `DW` iterations, then go to FIX.
  - FIX: write outputs, then go to IDLE.
- Width rules inside the datapath:
  - Dividend magnitude is held unsigned `DW` bits (32768 fits).
  - Divisor magnitude is held unsigned `VW` bits (128 fits).
  - Partial remainder is `VW`+1 bits.
- CALC step (restoring):
  - Shift the partial remainder left, bringing in the dividend MSB.
  - Trial-subtract the divisor magnitude.
  - If the result is non-negative, keep it and shift a 1 into the quotient; otherwise shift a 0.
- FIX sign rules:
  - Quotient is negated when the dividend and divisor signs differ.
  - Remainder is negated when the dividend is negative (remainder sign follows the dividend).
  - Result satisfies |R| < |divisor| and Dividend = Q·Divisor + R.
- Divide-by-zero (`Divisor`=0):
  - `Quotient`=16'hFFFF, `Remainder`=0, `err`=1.
  - Same latency as a normal division.
- Overflow (-32768 / -1):
  - `Quotient`=16'h8000 (wrapped), `Remainder`=0, `err`=1.
- `err`=0 for every other operand pair.
- `start` while `ready`=0 is ignored; the input operands are don't-care outside the `start` edge.
- Outputs hold their values from FIX until the next FIX or reset.
- `Quotient`, `Remainder` and `err` do not change during LOAD or CALC.

## Timing
- Edge 0: `start`=1 sampled, state goes to LOAD. `ready` falls after edge 0.
- Edge 1: LOAD.
- Edges 2 to 17: 16 CALC iterations.
- Edge 18: FIX. Outputs update and `ready` rises after edge 18.
- Latency is 18 cycles, fixed and operand-independent.
- A new `start` is accepted at edge 19 at the earliest, i.e. back-to-back operation every 19 cycles.
- `start` held high continuously starts a new division on each cycle where `ready`=1 at the sampling edge.
- `rst_n` asserted mid-operation aborts the division: outputs go to their reset values immediately (async), and the state is IDLE on release.

## Structure
- Package `div_pkg` holds:
  - `DW`/`VW` defaults.
  - State enum `div_state_t` (IDLE, LOAD, CALC, FIX).
  - Constants `Q_DIV0`=16'hFFFF and `Q_OVF`=16'h8000.
- One combinational sub-module `div_step` does the shift/trial-subtract/select for one iteration. It is instantiated once and reused each CALC cycle.
- Top level holds the FSM, the 5-bit iteration counter, the sign flags and the output registers.

## Test plan
- 1000 / 7 -> `Quotient`=142, `Remainder`=6, `err`=0, `ready` high exactly 18 cycles after the start edge.
- -1000 / 7 -> -142, -6. Then 1000 / -7 -> -142, 6. Then -1000 / -7 -> 142, -6.
- 1234 / 0 -> 16'hFFFF, 0, `err`=1. Then -32768 / -1 -> 16'h8000, 0, `err`=1. Then 127 / -128 -> 0, 127, `err`=0.
- Start 500 / 3, pulse `start` with 9 / 2 at cycle 5 -> second request ignored, result 166 / 2.
- Start 500 / 3, drop `rst_n` at cycle 6 -> outputs 0 and `ready`=1 immediately. After release, 20 / 6 -> 3, 2.
- Round-trip 100 random A, B pairs through the multiplier, then Product / B (B≠0) -> `Quotient`=A and `Remainder`=0 for every pair.

Source files
------------

// File: rtl/div_pkg.sv
// div_pkg: shared widths, FSM states and special-case quotients for signed_divider.
package div_pkg;
  localparam int DW = 16;
  localparam int VW = 8;
  typedef enum logic [1:0] {IDLE, LOAD, CALC, FIX} div_state_t;
  localparam logic [15:0] Q_DIV0 = 16'hFFFF;
  localparam logic [15:0] Q_OVF  = 16'h8000;
endpackage

// File: rtl/div_step.sv
// div_step: one restoring iteration - shift in the dividend MSB, trial-subtract, select.
module div_step #(
  parameter int DW = 16,
  parameter int VW = 8
) (
  input  logic [VW:0]   rem_i,
  input  logic [DW-1:0] dvd_i,
  input  logic [VW-1:0] dvs_i,
  output logic [VW:0]   rem_o,
  output logic [DW-1:0] dvd_o
);
  logic [VW:0] sh, diff;
  logic        borrow, ge;
  always_comb begin
    sh            = {rem_i[VW-1:0], dvd_i[DW-1]};
    {borrow, diff} = {1'b0, sh} - {2'b0, dvs_i};
    // a set top bit means the true shifted value exceeds any divisor magnitude
    ge            = ~borrow | rem_i[VW];
    rem_o         = ge ? diff : sh;
    dvd_o         = {dvd_i[DW-2:0], ge};
  end
endmodule

// File: rtl/signed_divider.sv
// signed_divider: sequential radix-2 restoring signed divider, fixed 18-cycle latency.
module signed_divider
  import div_pkg::*;
#(
  parameter int DW = div_pkg::DW,
  parameter int VW = div_pkg::VW
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          start,
  input  logic [DW-1:0] Dividend,
  input  logic [VW-1:0] Divisor,
  output logic [DW-1:0] Quotient,
  output logic [VW-1:0] Remainder,
  output logic          ready,
  output logic          err
);
  div_state_t    state_q, state_d;
  logic [DW-1:0] a_q, a_d, dvd_q, dvd_d, quo_q, quo_d, step_dvd;
  logic [VW-1:0] b_q, b_d, dvs_q, dvs_d, rmd_q, rmd_d;
  logic [VW:0]   rem_q, rem_d, step_rem;
  logic [4:0]    cnt_q, cnt_d;
  logic          err_q, err_d, div0, ovf, sq, sr, unused_rem;
  div_step #(.DW(DW), .VW(VW)) u_step (
    .rem_i(rem_q), .dvd_i(dvd_q), .dvs_i(dvs_q), .rem_o(step_rem), .dvd_o(step_dvd)
  );
  assign div0       = b_q == '0;
  assign ovf        = a_q == Q_OVF && b_q == '1;
  assign sr         = a_q[DW-1];
  assign sq         = a_q[DW-1] ^ b_q[VW-1];
  assign unused_rem = rem_q[VW];
  always_comb begin
    state_d = state_q;
    a_d     = a_q;
    b_d     = b_q;
    dvd_d   = dvd_q;
    dvs_d   = dvs_q;
    rem_d   = rem_q;
    cnt_d   = cnt_q;
    quo_d   = quo_q;
    rmd_d   = rmd_q;
    err_d   = err_q;
    case (state_q)
      IDLE: if (start) begin
        state_d = LOAD;
        a_d     = Dividend;
        b_d     = Divisor;
      end
      LOAD: begin
        dvd_d   = a_q[DW-1] ? -a_q : a_q;
        dvs_d   = b_q[VW-1] ? -b_q : b_q;
        rem_d   = '0;
        cnt_d   = '0;
        state_d = CALC;
      end
      CALC: begin
        dvd_d   = step_dvd;
        rem_d   = step_rem;
        cnt_d   = cnt_q + 5'd1;
        state_d = cnt_q == 5'(DW - 1) ? FIX : CALC;
      end
      FIX: begin
        quo_d   = div0 ? Q_DIV0 : ovf ? Q_OVF : sq ? -dvd_q : dvd_q;
        rmd_d   = (div0 || ovf) ? '0 : sr ? -rem_q[VW-1:0] : rem_q[VW-1:0];
        err_d   = div0 || ovf;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      a_q     <= '0;
      b_q     <= '0;
      dvd_q   <= '0;
      dvs_q   <= '0;
      rem_q   <= '0;
      cnt_q   <= '0;
      quo_q   <= '0;
      rmd_q   <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      a_q     <= a_d;
      b_q     <= b_d;
      dvd_q   <= dvd_d;
      dvs_q   <= dvs_d;
      rem_q   <= rem_d;
      cnt_q   <= cnt_d;
      quo_q   <= quo_d;
      rmd_q   <= rmd_d;
      err_q   <= err_d;
    end
  end
  assign Quotient  = quo_q;
  assign Remainder = rmd_q;
  assign err       = err_q;
  assign ready     = state_q == IDLE;
endmodule

// File: tb/tb_signed_divider.sv
// tb_signed_divider: directed vectors pushed to a scoreboard, checked by an independent monitor.
module tb_signed_divider;
  logic        clk = 1'b0, rst_n = 1'b0, start = 1'b0;
  logic [15:0] Dividend = '0, Quotient;
  logic [7:0]  Divisor = '0, Remainder;
  logic        ready, err;
  int          cyc = 0, checks = 0, errors = 0;
  typedef struct {logic [15:0] q; logic [7:0] r; logic e; int t;} exp_t;
  exp_t sb[$];

  signed_divider dut (
    .clk(clk), .rst_n(rst_n), .start(start), .Dividend(Dividend), .Divisor(Divisor),
    .Quotient(Quotient), .Remainder(Remainder), .ready(ready), .err(err)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic wait_ready();
    int n = 0;
    while (!ready && n < 100) begin
      @(negedge clk);
      n++;
    end
    if (!ready) check("ready_timeout", 32'(ready), 1);
  endtask

  task automatic issue(input int a, input int b);
    wait_ready();
    start    = 1'b1;
    Dividend = 16'(a);
    Divisor  = 8'(b);
    @(posedge clk);
    #1 start = 1'b0;
  endtask

  task automatic run(input int a, input int b, input int q, input int r, input logic e);
    issue(a, b);
    sb.push_back('{16'(q), 8'(r), e, cyc});
  endtask

  initial begin
    logic prev;
    exp_t x;
    prev = 1'b1;
    forever begin
      @(negedge clk);
      if (!rst_n) prev = 1'b1;
      else begin
        if (ready && !prev) begin
          if (sb.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL unexpected_result: got q=%0h r=%0h expected no result", Quotient, Remainder);
          end else begin
            x = sb.pop_front();
            check("quotient", 32'(Quotient), 32'(x.q));
            check("remainder", 32'(Remainder), 32'(x.r));
            check("err", 32'(err), 32'(x.e));
            check("latency", 32'(cyc - x.t), 18);
          end
        end
        prev = ready;
      end
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [7:0]  a, b;
    logic [15:0] p;
    int n;
    repeat (2) @(negedge clk);
    check("rst_quotient", 32'(Quotient), 0);
    check("rst_remainder", 32'(Remainder), 0);
    check("rst_err", 32'(err), 0);
    check("rst_ready", 32'(ready), 1);
    rst_n = 1'b1;
    @(negedge clk);
    run(1000, 7, 142, 6, 1'b0);
    run(-1000, 7, -142, -6, 1'b0);
    run(1000, -7, -142, 6, 1'b0);
    run(-1000, -7, 142, -6, 1'b0);
    run(1234, 0, 16'hFFFF, 0, 1'b1);
    run(-32768, -1, 16'h8000, 0, 1'b1);
    run(127, -128, 0, 127, 1'b0);
    run(500, 3, 166, 2, 1'b0);
    repeat (4) @(negedge clk);
    start = 1'b1; Dividend = 16'd9; Divisor = 8'd2;
    @(posedge clk);
    #1 start = 1'b0;
    issue(500, 3);
    repeat (4) @(negedge clk);
    @(posedge clk);
    #2 rst_n = 1'b0;
    #1;
    check("abort_quotient", 32'(Quotient), 0);
    check("abort_remainder", 32'(Remainder), 0);
    check("abort_err", 32'(err), 0);
    check("abort_ready", 32'(ready), 1);
    @(posedge clk);
    #2 rst_n = 1'b1;
    run(20, 6, 3, 2, 1'b0);
    for (int i = 0; i < 100; i++) begin
      a = 8'($urandom_range(0, 255));
      b = 8'($urandom_range(1, 255));
      p = {{8{a[7]}}, a} * {{8{b[7]}}, b};
      run(int'(p), int'(b), int'({{8{a[7]}}, a}), 0, 1'b0);
    end
    n = 0;
    while (sb.size() != 0 && n < 200) begin
      @(negedge clk);
      n++;
    end
    check("drain", 32'(sb.size()), 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
